psum_accum_buffer: RTL and testbench
====================================

// Module: psum_accum_buffer
// PURPOSE
//  Parametrised partial-sum collector behind the PE array; successor to the fixed 14-lane psum_outs tap in main.
//  Accumulates per-channel psums across a runtime number of passes, with optional saturation.
//  Drains the results serially over a valid/ready stream to the output/GLB writer.
// PARAMETERS
//  NUM_CH    14  number of psum channels (PE rows/columns feeding the buffer)
//  PSUM_W    32  signed psum width, input and accumulator
//  PASS_W    8   width of the num_passes configuration field
//  SATURATE  1   1: signed saturating add; 0: two's-complement wrap
// PORTS
//  clk           in   1              clock, rising edge
//  rst           in   1              asynchronous reset, active high
//  start         in   1              pulse: clear accumulators, latch num_passes, begin ACCUM
//  num_passes    in   PASS_W         passes to accumulate; sampled on start; 0 treated as 1
//  psum_in       in   NUM_CH*PSUM_W  packed psums, channel c at [c*PSUM_W +: PSUM_W]
//  psum_in_valid in   NUM_CH         per-channel psum strobe
//  pass_done     in   1              pulse: end of current pass
//  busy          out  1              high in ACCUM or DRAIN
//  out_valid     out  1              drain data valid
//  out_ready     in   1              downstream accept
//  out_data      out  PSUM_W         accumulated psum of channel out_ch
//  out_ch        out  $clog2(NUM_CH) channel index of out_data
//  out_last      out  1              high with out_valid on channel NUM_CH-1
//  done          out  1              one-cycle pulse after final drain handshake
//  overflow      out  1              sticky; set when any add saturates/wraps; cleared on start
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; all accumulators, counters and outputs 0.
//  FSM IDLE -> ACCUM -> DRAIN -> IDLE.
//  IDLE:
//   - start=1: acc[*]<=0, pass_cnt<=0, overflow<=0, passes_q<=max(num_passes,1); go ACCUM.
//   - psum_in_valid and pass_done ignored.
//  ACCUM:
//   - Each cycle, acc[c] <= acc[c] + psum_in[c] for every c with psum_in_valid[c]; one-cycle update latency.
//   - Add is signed PSUM_W. On overflow: SATURATE=1 clamps to max/min, SATURATE=0 wraps; either way sets overflow.
//   - pass_done with pass_cnt < passes_q-1: pass_cnt++.
//   - pass_done with pass_cnt == passes_q-1: go DRAIN, idx<=0.
//   - psum_in_valid coincident with the final pass_done is still accumulated.
//  DRAIN:
//   - out_valid=1; out_data=acc[idx]; out_ch=idx; out_last=(idx==NUM_CH-1).
//   - Outputs are registered-stable while out_valid && !out_ready.
//   - Handshake (valid&ready): idx++.
//   - Handshake on last: out_valid<=0, done<=1 for one cycle, go IDLE; acc values retained until next start.
//   - psum_in_valid and pass_done ignored.
//  start is ignored while busy (no restart mid-operation).
//  out_valid never depends combinationally on out_ready.
//  busy=0 in IDLE and on the done cycle.
//  Reset mid-ACCUM/DRAIN aborts; done is not pulsed.
// STRUCTURE
//  Shared package eyeriss_pkg:
//   - psum_state_e {IDLE, ACCUM, DRAIN}
//   - PSUM_W_DEF=32, NUM_CH_DEF=14
//   - function sat_add(a,b,sat) returning {ovf,sum}
//  Sub-module psum_acc_lane, generated NUM_CH times:
//   - one accumulator register + sat_add; ports clk, rst, clr, en, din, acc, ovf.
//  Top holds the FSM, pass counter, drain index, and output mux.
// TESTING
//  Reset-only -> all outputs 0; busy=0 for 10 cycles.
//  num_passes=1; each ch c gets psum c+1 once; pass_done
//   -> drain 1..14 in ch order, out_last on ch13, done one cycle after.
//  num_passes=3; ch0 gets 5 per pass
//   -> out_data ch0 = 15; pass_done on passes 1-2 stays in ACCUM.
//  SATURATE=1; ch0 gets 0x7FFFFFFF then 1
//   -> ch0 = 0x7FFFFFFF, overflow=1.
//  SATURATE=0, same stimulus -> ch0 = 0x80000000, overflow=1.
//  out_ready toggling 1010 during drain -> data/ch held while stalled; no loss or duplication.
//  rst asserted mid-DRAIN at ch5 -> out_valid=0 immediately; no done pulse.
//  Restart from IDLE: start again -> acc cleared; overflow=0.
//  start during ACCUM -> ignored.
//  num_passes=0 behaves as 1.

Source files
------------

// File: rtl/eyeriss_pkg.sv
// Shared types and helpers for the psum accumulation path.
package eyeriss_pkg;

  localparam int unsigned PSUM_W_DEF = 32;
  localparam int unsigned NUM_CH_DEF = 14;
  // Container width for sat_add; operand width w must be at most SAT_MAX_W-1.
  localparam int unsigned SAT_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } psum_state_e;

  typedef struct packed {
    logic                        ovf;
    logic signed [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Signed w-bit add of sign-extended operands; clamps when sat=1, wraps otherwise.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                       input logic signed [SAT_MAX_W-1:0] b,
                                       input int unsigned                 w,
                                       input logic                        sat);
    logic signed [SAT_MAX_W-1:0] one;
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    logic signed [SAT_MAX_W-1:0] full;
    logic signed [SAT_MAX_W-1:0] wrapped;
    int unsigned                 sh;
    sat_res_t                    res;
    one     = SAT_MAX_W'(1);
    max_v   = (one <<< (w - 1)) - one;
    min_v   = -max_v - one;
    full    = a + b;
    sh      = SAT_MAX_W - w;
    wrapped = (full <<< sh) >>> sh;
    res.ovf = (full > max_v) || (full < min_v);
    if (res.ovf && sat) begin
      res.sum = (full > max_v) ? max_v : min_v;
    end else begin
      res.sum = wrapped;
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// One psum accumulator channel: clear, accumulate with optional saturation, flag overflow.
module psum_acc_lane
  import eyeriss_pkg::*;
#(
  parameter int unsigned PSUM_W   = PSUM_W_DEF,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [PSUM_W-1:0] din,
  output logic signed [PSUM_W-1:0] acc,
  output logic                     ovf
);

  sat_res_t sum_c;

  // Next accumulator value from the shared saturating adder.
  always_comb begin
    sum_c = sat_add(SAT_MAX_W'(din), SAT_MAX_W'(acc), PSUM_W, SATURATE);
  end

  // Accumulator register; ovf flags the add committed on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= PSUM_W'(sum_c.sum);
      ovf <= sum_c.ovf;
    end else begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/psum_accum_buffer.sv
// Multi-pass per-channel psum accumulator with serial valid/ready drain.
module psum_accum_buffer
  import eyeriss_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned PSUM_W   = PSUM_W_DEF,
  parameter int unsigned PASS_W   = 8,
  parameter bit          SATURATE = 1'b1,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PASS_W-1:0]        num_passes,
  input  logic [NUM_CH*PSUM_W-1:0] psum_in,
  input  logic [NUM_CH-1:0]        psum_in_valid,
  input  logic                     pass_done,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [PSUM_W-1:0] out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic                     done,
  output logic                     overflow
);

  psum_state_e             state;
  logic [PASS_W-1:0]       pass_cnt;
  logic [PASS_W-1:0]       passes_q;
  logic [CH_W-1:0]         idx;
  logic [CH_W-1:0]         idx_nxt;
  logic                    lane_clr;
  logic [NUM_CH-1:0]       lane_en;
  logic [NUM_CH-1:0]       lane_ovf;
  logic signed [PSUM_W-1:0] acc_q [NUM_CH];

  assign lane_clr = (state == IDLE) && start;
  assign idx_nxt  = idx + CH_W'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign lane_en[c] = (state == ACCUM) && psum_in_valid[c];

    psum_acc_lane #(
      .PSUM_W   (PSUM_W),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (lane_clr),
      .en  (lane_en[c]),
      .din (psum_in[c*PSUM_W +: PSUM_W]),
      .acc (acc_q[c]),
      .ovf (lane_ovf[c])
    );
  end

  // Control FSM, pass counting and registered drain outputs.
  // DRAIN spends its first cycle loading channel 0, since the final pass's
  // adds land in the accumulators on the same edge that enters DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pass_cnt  <= '0;
      passes_q  <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (|lane_ovf) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            passes_q <= (num_passes == '0) ? PASS_W'(1) : num_passes;
            pass_cnt <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (pass_done) begin
            if (pass_cnt == passes_q - PASS_W'(1)) begin
              idx   <= '0;
              state <= DRAIN;
            end else begin
              pass_cnt <= pass_cnt + PASS_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= acc_q[idx];
            out_ch    <= idx;
            out_last  <= (idx == CH_W'(NUM_CH - 1));
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              idx      <= idx_nxt;
              out_data <= acc_q[idx_nxt];
              out_ch   <= idx_nxt;
              out_last <= (idx_nxt == CH_W'(NUM_CH - 1));
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Bench for psum_accum_buffer: saturating and wrapping instances driven in lockstep.
module tb_psum_accum_buffer;

  localparam int NCH  = 14;
  localparam int PW   = 32;
  localparam int PASW = 8;
  localparam int CHW  = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam longint MOD  = 64'sd4294967296;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [PASW-1:0]       num_passes = '0;
  logic [NCH*PW-1:0]     psum_in = '0;
  logic [NCH-1:0]        psum_in_valid = '0;
  logic                  pass_done = 1'b0;
  logic                  out_ready = 1'b0;

  logic                  busy_s, ov_s, ol_s, done_s, of_s;
  logic signed [PW-1:0]  od_s;
  logic [CHW-1:0]        och_s;
  logic                  busy_w, ov_w, ol_w, done_w, of_w;
  logic signed [PW-1:0]  od_w;
  logic [CHW-1:0]        och_w;

  psum_accum_buffer #(.NUM_CH(NCH), .PSUM_W(PW), .PASS_W(PASW), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .num_passes(num_passes), .psum_in(psum_in),
    .psum_in_valid(psum_in_valid), .pass_done(pass_done), .busy(busy_s), .out_valid(ov_s),
    .out_ready(out_ready), .out_data(od_s), .out_ch(och_s), .out_last(ol_s), .done(done_s),
    .overflow(of_s));

  psum_accum_buffer #(.NUM_CH(NCH), .PSUM_W(PW), .PASS_W(PASW), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .num_passes(num_passes), .psum_in(psum_in),
    .psum_in_valid(psum_in_valid), .pass_done(pass_done), .busy(busy_w), .out_valid(ov_w),
    .out_ready(out_ready), .out_data(od_w), .out_ch(och_w), .out_last(ol_w), .done(done_w),
    .overflow(of_w));

  always #5 clk = ~clk;

  // Reference model: per-channel sums as plain integers, phase 0 idle / 1 accum / 2 drain.
  longint m_acc_s [NCH];
  longint m_acc_w [NCH];
  bit     m_ovf_s, m_ovf_w;
  int     m_phase = 0;
  int     m_passes_left = 0;
  int     stim_vals [NCH];
  longint got_s [NCH];
  longint got_w [NCH];
  int     n_pass = 0;
  int     n_total = 0;

  typedef struct {
    int             np;
    int             v0;
    logic [NCH-1:0] mask;
    longint         exp_ch0;
    longint         exp_ch13;
  } vec_t;

  vec_t vecs [4];

  function automatic longint ref_add(input longint a, input longint b, input bit sat,
                                     output bit ovf);
    longint s;
    s   = a + b;
    ovf = (s > MAXV) || (s < MINV);
    if (s > MAXV) s = sat ? MAXV : s - MOD;
    else if (s < MINV) s = sat ? MINV : s + MOD;
    return s;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the model applies the same cycle at the behaviour level.
  task automatic drive(input bit st, input int np, input logic [NCH-1:0] mask, input bit pd);
    bit o;
    start         = st;
    num_passes    = PASW'(np);
    psum_in_valid = mask;
    pass_done     = pd;
    for (int c = 0; c < NCH; c++) psum_in[c*PW +: PW] = PW'(stim_vals[c]);
    if (m_phase == 0 && st) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc_s[c] = 0;
        m_acc_w[c] = 0;
      end
      m_ovf_s = 1'b0;
      m_ovf_w = 1'b0;
      m_passes_left = (np == 0) ? 1 : np;
      m_phase = 1;
    end else if (m_phase == 1) begin
      for (int c = 0; c < NCH; c++) begin
        if (mask[c]) begin
          m_acc_s[c] = ref_add(m_acc_s[c], longint'(stim_vals[c]), 1'b1, o);
          if (o) m_ovf_s = 1'b1;
          m_acc_w[c] = ref_add(m_acc_w[c], longint'(stim_vals[c]), 1'b0, o);
          if (o) m_ovf_w = 1'b1;
        end
      end
      if (pd) begin
        m_passes_left--;
        if (m_passes_left == 0) m_phase = 2;
      end
    end
    tick();
    start         = 1'b0;
    pass_done     = 1'b0;
    psum_in_valid = '0;
  endtask

  // Drain all channels; mode 0 always ready, 1 ready toggling 1010, 2 random ready.
  task automatic drain(input int mode);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    chk("model_in_drain", m_phase, 2);
    while (k < NCH && cyc < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (ov_s) begin
        chk("drain_data_sat", od_s, m_acc_s[k]);
        chk("drain_data_wrap", od_w, m_acc_w[k]);
        chk("drain_ch", och_s, k);
        chk("drain_last", ol_s, (k == NCH - 1) ? 1 : 0);
        if (out_ready) begin
          got_s[k] = od_s;
          got_w[k] = od_w;
          k++;
        end
      end else if (k > 0) begin
        chk("drain_valid_dropped", ov_s, 1);
      end
      tick();
      cyc++;
    end
    if (k < NCH) chk("drain_timeout_beats", k, NCH);
    out_ready = 1'b0;
    chk("done_pulse_sat", done_s, 1);
    chk("done_pulse_wrap", done_w, 1);
    chk("busy_on_done", busy_s, 0);
    chk("valid_after_last", ov_s, 0);
    m_phase = 0;
    tick();
    chk("done_single_cycle", done_s, 0);
    chk("overflow_sat", of_s, m_ovf_s);
    chk("overflow_wrap", of_w, m_ovf_w);
  endtask

  task automatic set_vals(input int v0);
    for (int c = 0; c < NCH; c++) stim_vals[c] = v0 + c;
  endtask

  task automatic rand_vals();
    for (int c = 0; c < NCH; c++)
      stim_vals[c] = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                                 : int'($urandom_range(0, 2000)) - 1000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     np_eff;
    int     wait_cyc;
    int     nc;
    logic [NCH-1:0] rmask;

    vecs[0] = '{np: 1, v0: 1,   mask: {NCH{1'b1}}, exp_ch0: 1,   exp_ch13: 14};
    vecs[1] = '{np: 3, v0: 5,   mask: 14'h0001,    exp_ch0: 15,  exp_ch13: 0};
    vecs[2] = '{np: 0, v0: 7,   mask: {NCH{1'b1}}, exp_ch0: 7,   exp_ch13: 20};
    vecs[3] = '{np: 2, v0: -10, mask: 14'h2001,    exp_ch0: -20, exp_ch13: 6};
    for (int c = 0; c < NCH; c++) stim_vals[c] = 0;

    // Reset state
    #12;
    chk("rst_busy", busy_s, 0);
    chk("rst_out_valid", ov_s, 0);
    chk("rst_out_data", od_s, 0);
    chk("rst_out_ch", och_s, 0);
    chk("rst_out_last", ol_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_overflow", of_s, 0);
    #5 rst = 1'b0;
    #3;
    // Idle ignores psum strobes and pass_done
    set_vals(100);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 0, {NCH{1'b1}}, 1'b1);
      chk("idle_busy", busy_s, 0);
      chk("idle_valid", ov_s, 0);
    end

    // Table-driven passes
    for (int v = 0; v < 4; v++) begin
      drive(1'b1, vecs[v].np, '0, 1'b0);
      chk("start_busy", busy_s, 1);
      np_eff = (vecs[v].np == 0) ? 1 : vecs[v].np;
      for (int p = 0; p < np_eff; p++) begin
        set_vals(vecs[v].v0);
        drive(1'b0, 0, vecs[v].mask, 1'b0);
        drive(1'b0, 0, '0, 1'b1);
        if (p < np_eff - 1) begin
          drive(1'b0, 0, '0, 1'b0);
          chk("midpass_busy", busy_s, 1);
          chk("midpass_no_valid", ov_s, 0);
        end
      end
      drain(0);
      chk("vec_ch0", got_s[0], vecs[v].exp_ch0);
      chk("vec_ch13", got_s[13], vecs[v].exp_ch13);
    end

    // Saturate vs wrap, valid coincident with final pass_done, ready toggling 1010
    for (int c = 0; c < NCH; c++) stim_vals[c] = 0;
    drive(1'b1, 1, '0, 1'b0);
    stim_vals[0] = 32'h7FFF_FFFF;
    drive(1'b0, 0, 14'h0001, 1'b0);
    stim_vals[0] = 1;
    drive(1'b0, 0, 14'h0001, 1'b1);
    drain(1);
    chk("sat_ch0", got_s[0], 64'sd2147483647);
    chk("wrap_ch0", got_w[0], -64'sd2147483648);
    chk("sat_overflow", of_s, 1);
    chk("wrap_overflow", of_w, 1);

    // Restart clears accumulators and overflow
    drive(1'b1, 1, '0, 1'b0);
    chk("restart_ovf_sat", of_s, 0);
    chk("restart_ovf_wrap", of_w, 0);
    chk("restart_busy", busy_s, 1);
    drive(1'b0, 0, '0, 1'b1);
    drain(0);

    // start during ACCUM is ignored (no clear, pass count kept)
    for (int c = 0; c < NCH; c++) stim_vals[c] = 0;
    drive(1'b1, 2, '0, 1'b0);
    stim_vals[0] = 3;
    drive(1'b0, 0, 14'h0001, 1'b0);
    stim_vals[0] = 4;
    drive(1'b1, 1, 14'h0001, 1'b0);
    drive(1'b0, 0, '0, 1'b1);
    drive(1'b0, 0, '0, 1'b0);
    chk("restart_ignored_busy", busy_s, 1);
    chk("restart_ignored_valid", ov_s, 0);
    stim_vals[0] = 1;
    drive(1'b0, 0, 14'h0001, 1'b1);
    drain(0);
    chk("restart_ignored_ch0", got_s[0], 8);

    // Reset mid-DRAIN at channel 5
    drive(1'b1, 1, '0, 1'b0);
    set_vals(1);
    drive(1'b0, 0, {NCH{1'b1}}, 1'b1);
    out_ready = 1'b1;
    wait_cyc = 0;
    while (!(ov_s && och_s == CHW'(5)) && wait_cyc < 50) begin
      tick();
      wait_cyc++;
    end
    chk("reach_ch5", och_s, 5);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", ov_s, 0);
    chk("abort_busy", busy_s, 0);
    chk("abort_done", done_s, 0);
    #3 rst = 1'b0;
    m_phase = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", done_s, 0);
      chk("abort_stay_idle", ov_s, 0);
    end
    out_ready = 1'b0;

    // Randomized runs against the model
    for (int it = 0; it < 8; it++) begin
      np_eff = $urandom_range(0, 4);
      drive(1'b1, np_eff, '0, 1'b0);
      if (np_eff == 0) np_eff = 1;
      for (int p = 0; p < np_eff; p++) begin
        nc = $urandom_range(0, 3);
        for (int j = 0; j < nc; j++) begin
          rand_vals();
          rmask = NCH'($urandom);
          drive(1'b0, 0, rmask, 1'b0);
        end
        rand_vals();
        rmask = NCH'($urandom);
        drive(1'b0, 0, rmask, 1'b1);
      end
      drain(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
